// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch sequencer: machine-cycle phase encodings
// and default widths for the program counter and return-address stack.
package fetch_unit_pkg;

  localparam int unsigned ADDR_WIDTH_DEF  = 12;
  localparam int unsigned STACK_DEPTH_DEF = 3;

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

endpackage

// File: rtl/fetch_unit_addr_stack.sv
// Circular return-address stack: register file, wrapping pointer and
// push/pop arbitration (pop wins). Top-of-stack is the entry below sp.
module addr_stack
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] ret_addr,
  output logic [ADDR_WIDTH-1:0] top
);

  localparam int unsigned SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_LAST = SP_W'(STACK_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] entry [STACK_DEPTH];
  logic [SP_W-1:0]       sp;
  logic [SP_W-1:0]       sp_inc;
  logic [SP_W-1:0]       sp_dec;

  always_comb begin
    sp_inc = (sp == SP_LAST) ? '0 : sp + SP_W'(1);
    sp_dec = (sp == '0) ? SP_LAST : sp - SP_W'(1);
  end

  assign top = entry[sp_dec];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sp <= '0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        entry[i] <= '0;
      end
    end else if (pop) begin
      sp <= sp_dec;
    end else if (push) begin
      entry[sp] <= ret_addr;
      sp        <= sp_inc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: 8-phase machine cycle, PC nibble bus output,
// opcode latches and call/return/jump handling at the end of X3.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [3:0]            data_in,
  output logic [3:0]            data_out,
  output logic                  data_oe,
  output logic                  sync,
  output logic [2:0]            phase,
  output logic [3:0]            opr,
  output logic [3:0]            opa,
  output logic [3:0]            opr2,
  output logic [3:0]            opa2,
  output logic                  in_second_word,
  input  logic                  need_second_word,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_value,
  input  logic                  stack_push,
  input  logic                  stack_pop,
  output logic [ADDR_WIDTH-1:0] pc
);

  phase_t                state;
  phase_t                state_next;
  logic                  at_x3;
  logic                  do_push;
  logic                  do_pop;
  logic [ADDR_WIDTH-1:0] stack_top;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= PH_A1;
    else          state <= state_next;
  end

  always_comb begin
    state_next = phase_t'(state + 3'd1);
    data_out   = '0;
    data_oe    = 1'b0;
    sync       = 1'b0;
    case (state)
      PH_A1: begin data_out = pc[3:0];  data_oe = 1'b1; end
      PH_A2: begin data_out = pc[7:4];  data_oe = 1'b1; end
      PH_A3: begin data_out = pc[11:8]; data_oe = 1'b1; end
      PH_X3: sync = 1'b1;
      default: ;
    endcase
  end

  assign phase   = state;
  assign at_x3   = (state == PH_X3);
  assign do_pop  = at_x3 & stack_pop;
  assign do_push = at_x3 & stack_push;

  addr_stack #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (do_push),
    .pop      (do_pop),
    .ret_addr (pc),
    .top      (stack_top)
  );

  // pc was already incremented in M2, so a push at X3 saves the return address
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc <= '0;
    end else if (state == PH_M2) begin
      pc <= pc + ADDR_WIDTH'(1);
    end else if (at_x3) begin
      if (stack_pop)       pc <= stack_top;
      else if (stack_push) pc <= pc_load_value;
      else if (pc_load)    pc <= pc_load_value;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      opr            <= '0;
      opa            <= '0;
      opr2           <= '0;
      opa2           <= '0;
      in_second_word <= 1'b0;
    end else begin
      if (state == PH_M1) begin
        if (in_second_word) opr2 <= data_in;
        else                opr  <= data_in;
      end
      if (state == PH_M2) begin
        if (in_second_word) opa2 <= data_in;
        else                opa  <= data_in;
      end
      if (at_x3) in_second_word <= ~in_second_word & need_second_word;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-phase vector table for the first cycles,
// then per-cycle sequences for jumps, the return stack, second words and reset.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  data_in;
  logic [3:0]  data_out;
  logic        data_oe;
  logic        sync;
  logic [2:0]  phase;
  logic [3:0]  opr, opa, opr2, opa2;
  logic        in_second_word;
  logic        need_second_word;
  logic        pc_load;
  logic [11:0] pc_load_value;
  logic        stack_push;
  logic        stack_pop;
  logic [11:0] pc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  fetch_unit #(.ADDR_WIDTH(12), .STACK_DEPTH(3)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .data_in          (data_in),
    .data_out         (data_out),
    .data_oe          (data_oe),
    .sync             (sync),
    .phase            (phase),
    .opr              (opr),
    .opa              (opa),
    .opr2             (opr2),
    .opa2             (opa2),
    .in_second_word   (in_second_word),
    .need_second_word (need_second_word),
    .pc_load          (pc_load),
    .pc_load_value    (pc_load_value),
    .stack_push       (stack_push),
    .stack_pop        (stack_pop),
    .pc               (pc)
  );

  typedef struct {
    logic [3:0]  din;
    logic        load;
    logic [11:0] lval;
    logic [2:0]  ph;
    logic [3:0]  dout;
    logic        oe;
    logic        sy;
    logic [11:0] pcv;
    logic [3:0]  opr_e;
    logic [3:0]  opa_e;
  } vec_t;

  vec_t vecs [32];

  function automatic vec_t mk(input logic [3:0] din, input logic load, input logic [11:0] lval,
                              input logic [2:0] ph, input logic [3:0] dout, input logic oe,
                              input logic sy, input logic [11:0] pcv, input logic [3:0] o_r,
                              input logic [3:0] o_a);
    vec_t v;
    v.din = din; v.load = load; v.lval = lval; v.ph = ph; v.dout = dout;
    v.oe = oe; v.sy = sy; v.pcv = pcv; v.opr_e = o_r; v.opa_e = o_a;
    return v;
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one full machine cycle starting at the falling edge inside A1 and
  // returns the address driven on the bus during A1..A3.
  task automatic fetch_cycle(input logic [3:0] d1, input logic [3:0] d2, input logic need,
                             input logic load, input logic push, input logic pop,
                             input logic [11:0] lval, output logic [11:0] addr);
    addr = '0;
    check("cycle_start_phase", 12'(phase), 12'd0);
    for (int p = 0; p < 8; p++) begin
      data_in = (p == 3) ? d1 : (p == 4) ? d2 : 4'h0;
      if (p < 3) addr[4*p +: 4] = data_out;
      if (p == 7) begin
        need_second_word = need;
        pc_load          = load;
        stack_push       = push;
        stack_pop        = pop;
        pc_load_value    = lval;
      end
      @(negedge clock);
      need_second_word = 1'b0;
      pc_load          = 1'b0;
      stack_push       = 1'b0;
      stack_pop        = 1'b0;
      pc_load_value    = '0;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a;

    vecs[0]  = mk(4'h0, 0, 12'h000, 3'd0, 4'h0, 1, 0, 12'h000, 4'h0, 4'h0);
    vecs[1]  = mk(4'h0, 0, 12'h000, 3'd1, 4'h0, 1, 0, 12'h000, 4'h0, 4'h0);
    vecs[2]  = mk(4'h0, 0, 12'h000, 3'd2, 4'h0, 1, 0, 12'h000, 4'h0, 4'h0);
    vecs[3]  = mk(4'h2, 0, 12'h000, 3'd3, 4'h0, 0, 0, 12'h000, 4'h0, 4'h0);
    vecs[4]  = mk(4'hA, 0, 12'h000, 3'd4, 4'h0, 0, 0, 12'h000, 4'h2, 4'h0);
    vecs[5]  = mk(4'h0, 0, 12'h000, 3'd5, 4'h0, 0, 0, 12'h001, 4'h2, 4'hA);
    vecs[6]  = mk(4'h0, 0, 12'h000, 3'd6, 4'h0, 0, 0, 12'h001, 4'h2, 4'hA);
    vecs[7]  = mk(4'h0, 0, 12'h000, 3'd7, 4'h0, 0, 1, 12'h001, 4'h2, 4'hA);
    vecs[8]  = mk(4'h0, 0, 12'h000, 3'd0, 4'h1, 1, 0, 12'h001, 4'h2, 4'hA);
    vecs[9]  = mk(4'h0, 0, 12'h000, 3'd1, 4'h0, 1, 0, 12'h001, 4'h2, 4'hA);
    vecs[10] = mk(4'h0, 0, 12'h000, 3'd2, 4'h0, 1, 0, 12'h001, 4'h2, 4'hA);
    vecs[11] = mk(4'h5, 0, 12'h000, 3'd3, 4'h0, 0, 0, 12'h001, 4'h2, 4'hA);
    vecs[12] = mk(4'h3, 0, 12'h000, 3'd4, 4'h0, 0, 0, 12'h001, 4'h5, 4'hA);
    vecs[13] = mk(4'h0, 0, 12'h000, 3'd5, 4'h0, 0, 0, 12'h002, 4'h5, 4'h3);
    vecs[14] = mk(4'h0, 0, 12'h000, 3'd6, 4'h0, 0, 0, 12'h002, 4'h5, 4'h3);
    vecs[15] = mk(4'h0, 1, 12'h3C5, 3'd7, 4'h0, 0, 1, 12'h002, 4'h5, 4'h3);
    vecs[16] = mk(4'h0, 0, 12'h000, 3'd0, 4'h5, 1, 0, 12'h3C5, 4'h5, 4'h3);
    vecs[17] = mk(4'h0, 0, 12'h000, 3'd1, 4'hC, 1, 0, 12'h3C5, 4'h5, 4'h3);
    vecs[18] = mk(4'h0, 0, 12'h000, 3'd2, 4'h3, 1, 0, 12'h3C5, 4'h5, 4'h3);
    vecs[19] = mk(4'h0, 0, 12'h000, 3'd3, 4'h0, 0, 0, 12'h3C5, 4'h5, 4'h3);
    vecs[20] = mk(4'h0, 0, 12'h000, 3'd4, 4'h0, 0, 0, 12'h3C5, 4'h0, 4'h3);
    vecs[21] = mk(4'h0, 0, 12'h000, 3'd5, 4'h0, 0, 0, 12'h3C6, 4'h0, 4'h0);
    vecs[22] = mk(4'h0, 0, 12'h000, 3'd6, 4'h0, 0, 0, 12'h3C6, 4'h0, 4'h0);
    vecs[23] = mk(4'h0, 1, 12'hFFF, 3'd7, 4'h0, 0, 1, 12'h3C6, 4'h0, 4'h0);
    vecs[24] = mk(4'h0, 0, 12'h000, 3'd0, 4'hF, 1, 0, 12'hFFF, 4'h0, 4'h0);
    vecs[25] = mk(4'h0, 0, 12'h000, 3'd1, 4'hF, 1, 0, 12'hFFF, 4'h0, 4'h0);
    vecs[26] = mk(4'h0, 0, 12'h000, 3'd2, 4'hF, 1, 0, 12'hFFF, 4'h0, 4'h0);
    vecs[27] = mk(4'h0, 0, 12'h000, 3'd3, 4'h0, 0, 0, 12'hFFF, 4'h0, 4'h0);
    vecs[28] = mk(4'h0, 0, 12'h000, 3'd4, 4'h0, 0, 0, 12'hFFF, 4'h0, 4'h0);
    vecs[29] = mk(4'h0, 0, 12'h000, 3'd5, 4'h0, 0, 0, 12'h000, 4'h0, 4'h0);
    vecs[30] = mk(4'h0, 0, 12'h000, 3'd6, 4'h0, 0, 0, 12'h000, 4'h0, 4'h0);
    vecs[31] = mk(4'h0, 0, 12'h000, 3'd7, 4'h0, 0, 1, 12'h000, 4'h0, 4'h0);

    reset_n = 1'b0; data_in = '0; need_second_word = 1'b0; pc_load = 1'b0;
    pc_load_value = '0; stack_push = 1'b0; stack_pop = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_phase", 12'(phase), 12'd0);
    check("rst_pc", pc, 12'h000);
    check("rst_opr", 12'(opr), 12'h0);
    check("rst_opa", 12'(opa), 12'h0);
    check("rst_opr2", 12'(opr2), 12'h0);
    check("rst_opa2", 12'(opa2), 12'h0);
    check("rst_isw", 12'(in_second_word), 12'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      data_in       = vecs[i].din;
      pc_load       = vecs[i].load;
      pc_load_value = vecs[i].lval;
      check($sformatf("v%0d_phase", i), 12'(phase), 12'(vecs[i].ph));
      check($sformatf("v%0d_dout", i), 12'(data_out), 12'(vecs[i].dout));
      check($sformatf("v%0d_oe", i), 12'(data_oe), 12'(vecs[i].oe));
      check($sformatf("v%0d_sync", i), 12'(sync), 12'(vecs[i].sy));
      check($sformatf("v%0d_pc", i), pc, vecs[i].pcv);
      check($sformatf("v%0d_opr", i), 12'(opr), 12'(vecs[i].opr_e));
      check($sformatf("v%0d_opa", i), 12'(opa), 12'(vecs[i].opa_e));
      @(negedge clock);
    end
    pc_load = 1'b0; pc_load_value = '0; data_in = '0;

    // wrap 0xFFF -> 0x000, then call/return
    fetch_cycle(0, 0, 0, 1, 0, 0, 12'h010, a); check("wrap_addr", a, 12'h000);
    fetch_cycle(0, 0, 0, 0, 1, 0, 12'h200, a); check("pre_call", a, 12'h010);
    fetch_cycle(0, 0, 0, 0, 0, 0, 12'h000, a); check("call_target", a, 12'h200);
    fetch_cycle(0, 0, 0, 0, 0, 1, 12'h000, a); check("callee_next", a, 12'h201);
    fetch_cycle(0, 0, 0, 0, 1, 0, 12'h300, a); check("return_addr", a, 12'h011);
    fetch_cycle(0, 0, 0, 1, 1, 1, 12'h555, a); check("call2_target", a, 12'h300);
    fetch_cycle(0, 0, 0, 0, 0, 1, 12'h000, a); check("pushpop_pop_wins", a, 12'h012);
    fetch_cycle(0, 0, 0, 1, 0, 0, 12'h100, a); check("empty_pop_wrap", a, 12'h000);

    // four pushes into a three-entry stack, then three pops
    fetch_cycle(0, 0, 0, 0, 1, 0, 12'h200, a); check("p1_from", a, 12'h100);
    fetch_cycle(0, 0, 0, 0, 1, 0, 12'h300, a); check("p2_from", a, 12'h200);
    fetch_cycle(0, 0, 0, 0, 1, 0, 12'h400, a); check("p3_from", a, 12'h300);
    fetch_cycle(0, 0, 0, 0, 1, 0, 12'h500, a); check("p4_from", a, 12'h400);
    fetch_cycle(0, 0, 0, 0, 0, 1, 12'h000, a); check("p4_target", a, 12'h500);
    fetch_cycle(0, 0, 0, 0, 0, 1, 12'h000, a); check("pop_r4", a, 12'h401);
    fetch_cycle(0, 0, 0, 0, 0, 1, 12'h000, a); check("pop_r3", a, 12'h301);
    fetch_cycle(0, 0, 0, 0, 0, 0, 12'h000, a); check("pop_r2", a, 12'h201);

    // two-word instruction
    fetch_cycle(4'h4, 4'h6, 1, 0, 0, 0, 12'h000, a); check("w1_addr", a, 12'h202);
    check("w1_opr", 12'(opr), 12'h4);
    check("w1_opa", 12'(opa), 12'h6);
    check("w2_isw_set", 12'(in_second_word), 12'h1);
    fetch_cycle(4'h7, 4'h1, 1, 0, 0, 0, 12'h000, a); check("w2_addr", a, 12'h203);
    check("w2_opr2", 12'(opr2), 12'h7);
    check("w2_opa2", 12'(opa2), 12'h1);
    check("w2_opr_held", 12'(opr), 12'h4);
    check("w2_opa_held", 12'(opa), 12'h6);
    check("w2_need_ignored", 12'(in_second_word), 12'h0);
    fetch_cycle(4'h8, 4'h9, 1, 0, 0, 0, 12'h000, a); check("w3_addr", a, 12'h204);
    check("w3_isw_set", 12'(in_second_word), 12'h1);

    // asynchronous reset in M1 of a second-word cycle
    repeat (3) @(negedge clock);
    check("pre_rst_phase", 12'(phase), 12'd3);
    check("pre_rst_isw", 12'(in_second_word), 12'h1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_phase", 12'(phase), 12'd0);
    check("mid_rst_pc", pc, 12'h000);
    check("mid_rst_isw", 12'(in_second_word), 12'h0);
    check("mid_rst_opr", 12'(opr), 12'h0);
    check("mid_rst_opr2", 12'(opr2), 12'h0);
    @(negedge clock);
    reset_n = 1'b1;
    fetch_cycle(0, 0, 0, 0, 0, 0, 12'h000, a); check("post_rst_addr", a, 12'h000);
    check("post_rst_pc", pc, 12'h001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
